l_step_barrier_sync: RTL and testbench

Parametrised step-barrier controller for the diffusion engine. It launches each diffusion step to NUM_PE processing elements, collects their `finished` flags into a sticky barrier, and advances `l_step` once per completed step up to a programmable limit. Step counting is edge-safe: level-high `finished` flags never double-count. It adds a channel mask, start/abort control, a per-step timeout and late-PE reporting. It sits between the PS control registers and the PE array.

---
 rtl/l_step_pkg.sv | 22 ++
 rtl/l_step_barrier_sync_collect.sv | 35 +++
 rtl/l_step_barrier_sync.sv | 144 ++++++++++++++
 tb/tb_l_step_barrier_sync.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l_step_pkg.sv
// Shared types and helpers for the diffusion step-barrier controller.
package l_step_pkg;

    localparam int unsigned NUM_PE_MAX = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_e;

    // True when the low n bits of v are all ones; bits above n are padded high.
    function automatic logic all_ones(input logic [NUM_PE_MAX-1:0] v, input int unsigned n);
        logic [NUM_PE_MAX-1:0] pad;
        pad = {NUM_PE_MAX{1'b1}} << n;
        return &(v | pad);
    endfunction

endpackage

// File: rtl/l_step_barrier_sync_collect.sv
// Sticky per-PE arrival register with barrier-met and missing-channel views.
module barrier_collect
    import l_step_pkg::*;
#(
    parameter int unsigned NUM_PE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              collect,
    input  logic [NUM_PE-1:0] mask,
    input  logic [NUM_PE-1:0] finished,
    output logic              all_arrived,
    output logic [NUM_PE-1:0] missing
);

    logic [NUM_PE-1:0] arrived;
    logic [NUM_PE-1:0] seen;

    // Include this cycle's flags so the last arrival closes the barrier at once.
    assign seen        = arrived | (finished & mask);
    assign missing     = mask & ~seen;
    assign all_arrived = all_ones(NUM_PE_MAX'(seen | ~mask), NUM_PE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arrived <= '0;
        end else if (clear) begin
            arrived <= '0;
        end else if (collect) begin
            arrived <= seen;
        end
    end

endmodule

// File: rtl/l_step_barrier_sync.sv
// Step-barrier controller: launches steps to the PE array, waits on a masked
// sticky barrier, counts completed steps and reports per-step timeouts.
module l_step_barrier_sync
    import l_step_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_PE     = 16,
    parameter int unsigned TIMEOUT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] max_steps_cfg,
    input  logic [NUM_PE-1:0]     pe_mask,
    input  logic [TIMEOUT_W-1:0]  timeout_cycles,
    input  logic [NUM_PE-1:0]     finished,
    output logic                  step_go,
    output logic [DATA_WIDTH-1:0] l_step,
    output logic                  busy,
    output logic                  all_done,
    output logic                  timeout_err,
    output logic [NUM_PE-1:0]     late_pe
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] max_q;
    logic [NUM_PE-1:0]     mask_q;
    logic [TIMEOUT_W-1:0]  tmo_q;
    logic [TIMEOUT_W-1:0]  timer_q, timer_d;
    logic [DATA_WIDTH-1:0] l_step_d;
    logic [NUM_PE-1:0]     late_pe_d;
    logic                  cfg_load;
    logic                  arr_clear;
    logic                  arr_collect;
    logic                  all_arrived;
    logic [NUM_PE-1:0]     missing;

    barrier_collect #(
        .NUM_PE (NUM_PE)
    ) u_collect (
        .clk         (clk),
        .rst         (rst),
        .clear       (arr_clear),
        .collect     (arr_collect),
        .mask        (mask_q),
        .finished    (finished),
        .all_arrived (all_arrived),
        .missing     (missing)
    );

    // Next-state, counter and timer logic; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        l_step_d    = l_step;
        late_pe_d   = late_pe;
        timer_d     = timer_q;
        cfg_load    = 1'b0;
        arr_clear   = 1'b0;
        arr_collect = 1'b0;

        if (abort) begin
            state_d   = ST_IDLE;
            l_step_d  = '0;
            late_pe_d = '0;
            timer_d   = '0;
            arr_clear = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        cfg_load  = 1'b1;
                        l_step_d  = '0;
                        late_pe_d = '0;
                        timer_d   = '0;
                        arr_clear = 1'b1;
                        state_d   = (max_steps_cfg == '0) ? ST_DONE : ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    arr_clear = 1'b1;
                    timer_d   = '0;
                    state_d   = ST_WAIT;
                end
                ST_WAIT: begin
                    arr_collect = 1'b1;
                    if (all_arrived) begin
                        if (l_step != max_q) begin
                            l_step_d = l_step + DATA_WIDTH'(1);
                        end
                        state_d = ST_RELEASE;
                    end else if ((tmo_q != '0) && (timer_q == tmo_q - TIMEOUT_W'(1))) begin
                        late_pe_d = missing;
                        state_d   = ST_ERR;
                    end else begin
                        timer_d = timer_q + TIMEOUT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // Hold off the next launch until level-high flags drop.
                    if ((finished & mask_q) == '0) begin
                        state_d = (l_step == max_q) ? ST_DONE : ST_LAUNCH;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            l_step      <= '0;
            late_pe     <= '0;
            timer_q     <= '0;
            max_q       <= '0;
            mask_q      <= '0;
            tmo_q       <= '0;
            step_go     <= 1'b0;
            busy        <= 1'b0;
            all_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            l_step      <= l_step_d;
            late_pe     <= late_pe_d;
            timer_q     <= timer_d;
            if (cfg_load) begin
                max_q  <= max_steps_cfg;
                mask_q <= pe_mask;
                tmo_q  <= timeout_cycles;
            end
            step_go     <= (state_d == ST_LAUNCH);
            busy        <= (state_d == ST_LAUNCH) || (state_d == ST_WAIT) ||
                           (state_d == ST_RELEASE);
            all_done    <= (state_d == ST_DONE);
            timeout_err <= (state_d == ST_ERR);
        end
    end

endmodule

// File: tb/tb_l_step_barrier_sync.sv
// Scenario bench for l_step_barrier_sync with an l_step scoreboard and PE model.
module tb_l_step_barrier_sync;

    localparam int unsigned DW = 32;
    localparam int unsigned NP = 16;
    localparam int unsigned TW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [DW-1:0] max_steps_cfg;
    logic [NP-1:0] pe_mask;
    logic [TW-1:0] timeout_cycles;
    logic [NP-1:0] finished;
    logic          step_go;
    logic [DW-1:0] l_step;
    logic          busy;
    logic          all_done;
    logic          timeout_err;
    logic [NP-1:0] late_pe;

    int n_checks = 0;
    int n_fail   = 0;
    int go_cnt   = 0;
    int since    = 100000;
    int hold_cfg = 1;
    int delay_cfg [NP] = '{default: -1};
    logic [DW-1:0] exp_q [$];

    l_step_barrier_sync #(
        .DATA_WIDTH (DW),
        .NUM_PE     (NP),
        .TIMEOUT_W  (TW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .max_steps_cfg  (max_steps_cfg),
        .pe_mask        (pe_mask),
        .timeout_cycles (timeout_cycles),
        .finished       (finished),
        .step_go        (step_go),
        .l_step         (l_step),
        .busy           (busy),
        .all_done       (all_done),
        .timeout_err    (timeout_err),
        .late_pe        (late_pe)
    );

    always #5 clk = ~clk;

    // PE model: PE i raises finished delay_cfg[i] cycles after step_go for hold_cfg cycles.
    initial begin : pe_model
        finished = '0;
        forever begin
            @(posedge clk);
            #1;
            if (step_go === 1'b1) since = 0;
            else if (since < 100000) since++;
            for (int i = 0; i < NP; i++)
                finished[i] = (delay_cfg[i] >= 0) && (since >= delay_cfg[i]) &&
                              (since < delay_cfg[i] + hold_cfg);
        end
    end

    // Scoreboard: every nonzero l_step update must match the next expected value.
    initial begin : monitor
        logic [DW-1:0] prev;
        logic [DW-1:0] e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (step_go === 1'b1) go_cnt++;
            if (l_step !== prev) begin
                if (l_step !== '0) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL l_step_unexpected: got %0d, none expected", l_step);
                    end else begin
                        e = exp_q.pop_front();
                        if (l_step !== e) begin
                            n_fail++;
                            $display("FAIL l_step_seq: got %0d, required %0d", l_step, e);
                        end
                    end
                end
                prev = l_step;
            end
        end
    end

    task automatic pulse_start(input logic [DW-1:0] mx, input logic [NP-1:0] m,
                               input logic [TW-1:0] t);
        @(negedge clk);
        max_steps_cfg  = mx;
        pe_mask        = m;
        timeout_cycles = t;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic set_delays(input int d);
        for (int i = 0; i < NP; i++) delay_cfg[i] = d;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({step_go, busy, all_done, timeout_err} !== 4'b0 || l_step !== '0 || late_pe !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: go=%b busy=%b done=%b err=%b l_step=%0d late=%h, required all 0",
                     step_go, busy, all_done, timeout_err, l_step, late_pe);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({step_go, busy, all_done, timeout_err} !== 4'b0 || l_step !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: go=%b busy=%b done=%b err=%b l_step=%0d, required all 0",
                     step_go, busy, all_done, timeout_err, l_step);
        end
    endtask

    task automatic test_basic;
        int base;
        int cyc;
        set_delays(5);
        hold_cfg = 1;
        exp_q.push_back(DW'(1));
        exp_q.push_back(DW'(2));
        exp_q.push_back(DW'(3));
        base = go_cnt;
        pulse_start(DW'(3), 16'hFFFF, '0);
        cyc = 0;
        while (all_done !== 1'b1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (go_cnt - base != 3) begin
            n_fail++;
            $display("FAIL basic_go_count: got %0d, required 3", go_cnt - base);
        end
        n_checks++;
        if (all_done !== 1'b1 || busy !== 1'b0 || l_step !== DW'(3)) begin
            n_fail++;
            $display("FAIL basic_final: done=%b busy=%b l_step=%0d, required 1 0 3",
                     all_done, busy, l_step);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_sb_empty: %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_hold;
        int g;
        int cyc;
        set_delays(5);
        hold_cfg = 20;
        exp_q.push_back(DW'(1));
        exp_q.push_back(DW'(2));
        pulse_start(DW'(2), 16'hFFFF, '0);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (step_go !== 1'b1 && g < 200);
        n_checks++;
        if (g != 26 || l_step !== DW'(1)) begin
            n_fail++;
            $display("FAIL hold_gap: gap=%0d l_step=%0d, required 26 1", g, l_step);
        end
        cyc = 0;
        while (all_done !== 1'b1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (all_done !== 1'b1 || l_step !== DW'(2) || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL hold_final: done=%b l_step=%0d left=%0d, required 1 2 0",
                     all_done, l_step, exp_q.size());
        end
        hold_cfg = 1;
    endtask

    task automatic test_mask_stagger;
        int cyc;
        for (int i = 0; i < NP; i++) delay_cfg[i] = (i < 8) ? 3 + i : -1;
        hold_cfg = 1;
        exp_q.push_back(DW'(1));
        exp_q.push_back(DW'(2));
        pulse_start(DW'(2), 16'h00FF, '0);
        cyc = 0;
        while (l_step === '0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (since != 11) begin
            n_fail++;
            $display("FAIL stagger_latency: barrier at step cycle %0d, required 11", since);
        end
        cyc = 0;
        while (all_done !== 1'b1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (all_done !== 1'b1 || l_step !== DW'(2) || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stagger_final: done=%b l_step=%0d left=%0d, required 1 2 0",
                     all_done, l_step, exp_q.size());
        end
    endtask

    task automatic test_timeout;
        int cyc;
        set_delays(5);
        delay_cfg[5] = -1;
        hold_cfg = 1;
        pulse_start(DW'(3), 16'hFFFF, TW'(50));
        cyc = 0;
        while (timeout_err !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (timeout_err !== 1'b1 || since != 51) begin
            n_fail++;
            $display("FAIL timeout_when: err=%b at step cycle %0d, required 1 at 51", timeout_err, since);
        end
        n_checks++;
        if (late_pe !== 16'h0020 || l_step !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_state: late=%h l_step=%0d busy=%b, required 0020 0 0",
                     late_pe, l_step, busy);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (timeout_err !== 1'b1 || late_pe !== 16'h0020) begin
            n_fail++;
            $display("FAIL timeout_hold: err=%b late=%h, required 1 0020", timeout_err, late_pe);
        end
        delay_cfg[5] = 5;
        exp_q.push_back(DW'(1));
        pulse_start(DW'(1), 16'hFFFF, TW'(50));
        n_checks++;
        if (timeout_err !== 1'b0 || late_pe !== '0 || l_step !== '0 || step_go !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_restart: err=%b late=%h l_step=%0d go=%b, required 0 0000 0 1",
                     timeout_err, late_pe, l_step, step_go);
        end
        cyc = 0;
        while (all_done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (all_done !== 1'b1 || l_step !== DW'(1) || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_rerun: done=%b l_step=%0d left=%0d, required 1 1 0",
                     all_done, l_step, exp_q.size());
        end
    endtask

    task automatic test_coincide;
        int  cyc;
        logic err_seen;
        set_delays(8);
        hold_cfg = 1;
        exp_q.push_back(DW'(1));
        pulse_start(DW'(1), 16'hFFFF, TW'(8));
        err_seen = 1'b0;
        cyc = 0;
        while (all_done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            if (timeout_err === 1'b1) err_seen = 1'b1;
            cyc++;
        end
        n_checks++;
        if (err_seen || all_done !== 1'b1 || l_step !== DW'(1) || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL coincide: err_seen=%b done=%b l_step=%0d left=%0d, required 0 1 1 0",
                     err_seen, all_done, l_step, exp_q.size());
        end
    endtask

    task automatic test_abort;
        int base;
        int cyc;
        set_delays(5);
        hold_cfg = 1;
        exp_q.push_back(DW'(1));
        base = go_cnt;
        pulse_start(DW'(5), 16'hFFFF, '0);
        cyc = 0;
        while (go_cnt - base < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if ({step_go, busy, all_done, timeout_err} !== 4'b0 || l_step !== '0 || late_pe !== '0) begin
            n_fail++;
            $display("FAIL abort_idle: go=%b busy=%b done=%b err=%b l_step=%0d late=%h, required all 0",
                     step_go, busy, all_done, timeout_err, l_step, late_pe);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL abort_sb: %0d left, required 0", exp_q.size());
        end
        base = go_cnt;
        pulse_start('0, 16'hFFFF, '0);
        n_checks++;
        if (all_done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL max0_done: done=%b busy=%b, required 1 0", all_done, busy);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (go_cnt != base || l_step !== '0) begin
            n_fail++;
            $display("FAIL max0_nogo: go pulses=%0d l_step=%0d, required 0 0", go_cnt - base, l_step);
        end
        max_steps_cfg = DW'(3);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (all_done !== 1'b0 || busy !== 1'b0 || go_cnt != base) begin
            n_fail++;
            $display("FAIL abort_over_start: done=%b busy=%b go pulses=%0d, required 0 0 0",
                     all_done, busy, go_cnt - base);
        end
    endtask

    task automatic test_reset_release;
        int cyc;
        set_delays(5);
        hold_cfg = 20;
        exp_q.push_back(DW'(1));
        pulse_start(DW'(2), 16'hFFFF, '0);
        cyc = 0;
        while (l_step !== DW'(1) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({step_go, busy, all_done, timeout_err} !== 4'b0 || l_step !== '0 || late_pe !== '0) begin
            n_fail++;
            $display("FAIL reset_release: go=%b busy=%b done=%b err=%b l_step=%0d late=%h, required all 0",
                     step_go, busy, all_done, timeout_err, l_step, late_pe);
        end
        set_delays(-1);
        hold_cfg = 1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_after: busy=%b left=%0d, required 0 0", busy, exp_q.size());
        end
    endtask

    initial begin
        rst            = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        max_steps_cfg  = '0;
        pe_mask        = '0;
        timeout_cycles = '0;
        test_reset;
        test_basic;
        test_hold;
        test_mask_stagger;
        test_timeout;
        test_coincide;
        test_abort;
        test_reset_release;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
